// File: rtl/fb_porta_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : fb_porta_arbiter_if
//  Description : Bus bundle for framebuffer port A. It carries the CPU
//                request/response, the fill-engine control and the BSRAM
//                port-A pins.
//  Revision    : 1.0  initial release
// ============================================================================
interface fb_porta_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              fill_start;
    logic [ADDR_W-1:0] fill_base;
    logic [ADDR_W:0]   fill_len;
    logic [DATA_W-1:0] fill_value;
    logic              fill_busy;
    logic              fill_done;
    logic              bram_cea;
    logic              bram_ocea;
    logic              bram_wrea;
    logic [ADDR_W-1:0] bram_ada;
    logic [DATA_W-1:0] bram_dina;
    logic [DATA_W-1:0] bram_douta;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  fill_start, fill_base, fill_len, fill_value,
        input  bram_douta,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output fill_busy, fill_done,
        output bram_cea, bram_ocea, bram_wrea, bram_ada, bram_dina
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output fill_start, fill_base, fill_len, fill_value,
        output bram_douta,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  fill_busy, fill_done,
        input  bram_cea, bram_ocea, bram_wrea, bram_ada, bram_dina
    );
endinterface
`default_nettype wire

// File: rtl/fb_porta_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fb_porta_arbiter
//  Description : Owns framebuffer BSRAM port A. Each cycle it grants at most
//                one access, either to the CPU or to the constant-byte fill
//                engine. A streak counter makes sure that a pending fill still
//                gets a slot under continuous CPU load.
//  Revision    : 1.0  initial release
// ============================================================================
module fb_porta_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 2
) (
    input  wire logic           clka,
    input  wire logic           reseta,
    fb_porta_arbiter_if.slave   bus
);
    localparam int c_STRK_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_STRK_W-1:0] c_STARVE = c_STRK_W'(STARVE_MAX);
    localparam logic [ADDR_W:0]     c_REM_ONE = (ADDR_W + 1)'(1);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_FILL = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_rem;
    logic [DATA_W-1:0]   r_value;
    logic [c_STRK_W-1:0] r_streak;
    logic                r_done;
    logic                r_rvalid;

    logic w_busy;
    logic w_fill_slot;
    logic w_cpu_gnt;
    logic w_last;
    logic w_accept;
    logic w_len_zero;

    // The fill takes the slot when the CPU is idle or has used up its streak.
    assign w_busy      = (r_state == c_S_FILL);
    assign w_fill_slot = w_busy & (~bus.cpu_req | (r_streak == c_STARVE));
    assign w_cpu_gnt   = bus.cpu_req & ~w_fill_slot;
    assign w_last      = w_fill_slot & (r_rem == c_REM_ONE);
    assign w_accept    = ~w_busy & bus.fill_start;
    assign w_len_zero  = (bus.fill_len == '0);

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.cpu_rvalid = r_rvalid;
    assign bus.cpu_rdata  = bus.bram_douta;
    assign bus.fill_busy  = w_busy;
    assign bus.fill_done  = r_done;
    assign bus.bram_ocea  = 1'b1;

    // State register
    always_ff @(posedge clka or posedge reseta) begin
        if (reseta) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: enter FILL on a non-empty start, leave on the final write
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept && !w_len_zero) w_state_nxt = c_S_FILL;
            c_S_FILL: if (w_last)                  w_state_nxt = c_S_IDLE;
            default:                               w_state_nxt = c_S_IDLE;
        endcase
    end

    // Port-A pin drive for whichever requester owns this cycle
    always_comb begin
        bus.bram_cea  = 1'b0;
        bus.bram_wrea = 1'b0;
        bus.bram_ada  = '0;
        bus.bram_dina = '0;
        if (w_fill_slot) begin
            bus.bram_cea  = 1'b1;
            bus.bram_wrea = 1'b1;
            bus.bram_ada  = r_ptr;
            bus.bram_dina = r_value;
        end else if (w_cpu_gnt) begin
            bus.bram_cea  = 1'b1;
            bus.bram_wrea = bus.cpu_we;
            bus.bram_ada  = bus.cpu_addr;
            bus.bram_dina = bus.cpu_wdata;
        end
    end

    // Fill pointer/remaining count, streak, done pulse and read-valid pipeline
    always_ff @(posedge clka or posedge reseta) begin
        if (reseta) begin
            r_ptr    <= '0;
            r_rem    <= '0;
            r_value  <= '0;
            r_streak <= '0;
            r_done   <= 1'b0;
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_cpu_gnt & ~bus.cpu_we;
            r_done   <= w_last | (w_accept & w_len_zero);

            if (w_accept && !w_len_zero) begin
                r_ptr   <= bus.fill_base;
                r_rem   <= bus.fill_len;
                r_value <= bus.fill_value;
            end else if (w_fill_slot) begin
                r_ptr <= r_ptr + 1'b1;
                r_rem <= r_rem - c_REM_ONE;
            end

            if (!w_busy || w_fill_slot) begin
                r_streak <= '0;
            end else if (w_cpu_gnt) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fb_porta_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_porta_arbiter
//  Description : Self-checking bench for fb_porta_arbiter. It runs directed
//                scenarios and then random traffic, and compares every cycle
//                against a queue-based reference model. A behavioural BSRAM is
//                attached to port A.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fb_porta_arbiter;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 8;
    localparam int STARVE_MAX = 2;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clka;
    logic reseta;

    fb_porta_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_porta_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clka   (clka),
        .reseta (reseta),
        .bus    (bus)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    // Behavioural port-A BSRAM
    logic [DATA_W-1:0] bram_mem [0:DEPTH-1];
    initial begin
        for (int i = 0; i < DEPTH; i++) bram_mem[i] = '0;
        bus.bram_douta = '0;
    end
    always @(posedge clka) begin
        if (bus.bram_cea) begin
            if (bus.bram_wrea) bram_mem[bus.bram_ada] <= bus.bram_dina;
            else               bus.bram_douta <= bram_mem[bus.bram_ada];
        end
    end

    // Reference model: expected memory image, queue of pending fill addresses
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned m_mem [0:DEPTH-1];
    int unsigned m_q [$];
    int unsigned m_fval = 0;
    int unsigned m_run  = 0;
    bit          m_done = 0;
    bit          m_rv   = 0;
    int unsigned m_rd   = 0;
    bit          m_gnt  = 0;
    int unsigned n_fill_slots = 0;
    int unsigned n_done_seen  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare one cycle against the model, then advance the model at the edge
    task automatic step();
        bit pend, ef, eg;
        int unsigned e_wr, e_ad, e_di;
        #1;
        pend = (m_q.size() > 0);
        ef   = pend && (!bus.cpu_req || m_run >= STARVE_MAX);
        eg   = bus.cpu_req && !ef;
        e_wr = ef ? 1 : (eg ? 32'(bus.cpu_we) : 0);
        e_ad = ef ? m_q[0] : (eg ? 32'(bus.cpu_addr) : 0);
        e_di = ef ? m_fval : (eg ? 32'(bus.cpu_wdata) : 0);
        check("cpu_gnt",    32'(bus.cpu_gnt),    32'(eg));
        check("bram_cea",   32'(bus.bram_cea),   32'(ef | eg));
        check("bram_wrea",  32'(bus.bram_wrea),  e_wr);
        check("bram_ada",   32'(bus.bram_ada),   e_ad);
        check("bram_dina",  32'(bus.bram_dina),  e_di);
        check("bram_ocea",  32'(bus.bram_ocea),  32'd1);
        check("fill_busy",  32'(bus.fill_busy),  32'(pend));
        check("fill_done",  32'(bus.fill_done),  32'(m_done));
        check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_rv));
        if (m_rv) check("cpu_rdata", 32'(bus.cpu_rdata), m_rd);
        if (bus.fill_done) n_done_seen++;
        m_gnt = eg;
        @(posedge clka);
        m_done = 0;
        m_rv   = 0;
        if (eg) begin
            if (bus.cpu_we) m_mem[bus.cpu_addr] = 32'(bus.cpu_wdata);
            else begin
                m_rv = 1;
                m_rd = m_mem[bus.cpu_addr];
            end
            if (pend) m_run++;
        end
        if (ef) begin
            n_fill_slots++;
            m_mem[m_q[0]] = m_fval;
            void'(m_q.pop_front());
            m_run = 0;
            if (m_q.size() == 0) m_done = 1;
        end
        if (!pend) begin
            m_run = 0;
            if (bus.fill_start) begin
                if (bus.fill_len == 0) m_done = 1;
                else begin
                    for (int i = 0; i < int'(bus.fill_len); i++)
                        m_q.push_back((32'(bus.fill_base) + i) % DEPTH);
                    m_fval = 32'(bus.fill_value);
                end
            end
        end
        @(negedge clka);
    endtask

    task automatic do_reset();
        bus.cpu_req    = 1'b0;
        bus.fill_start = 1'b0;
        reseta = 1'b1;
        #1;
        check("rst_busy",   32'(bus.fill_busy),  32'd0);
        check("rst_cea",    32'(bus.bram_cea),   32'd0);
        check("rst_gnt",    32'(bus.cpu_gnt),    32'd0);
        check("rst_done",   32'(bus.fill_done),  32'd0);
        check("rst_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        check("rst_ada",    32'(bus.bram_ada),   32'd0);
        check("rst_dina",   32'(bus.bram_dina),  32'd0);
        m_q.delete();
        m_run  = 0;
        m_done = 0;
        m_rv   = 0;
        @(posedge clka);
        @(negedge clka);
        reseta = 1'b0;
    endtask

    task automatic cpu(input bit req, input bit we, input int unsigned addr, input int unsigned data);
        bus.cpu_req   = req;
        bus.cpu_we    = we;
        bus.cpu_addr  = ADDR_W'(addr);
        bus.cpu_wdata = DATA_W'(data);
    endtask

    task automatic fill(input int unsigned base, input int unsigned len, input int unsigned val);
        bus.fill_start = 1'b1;
        bus.fill_base  = ADDR_W'(base);
        bus.fill_len   = (ADDR_W + 1)'(len);
        bus.fill_value = DATA_W'(val);
    endtask

    // Idle cycles until the model has no fill pending, bounded
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((m_q.size() > 0 || m_done) && n < budget) begin
            step();
            bus.fill_start = 1'b0;
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
    endtask

    initial begin
        int unsigned slots0, dones0;
        bit hold;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        reseta = 1'b1;
        cpu(0, 0, 0, 0);
        bus.fill_start = 1'b0;
        bus.fill_base  = '0;
        bus.fill_len   = '0;
        bus.fill_value = '0;
        @(negedge clka);
        do_reset();

        // CPU write then read-back
        cpu(1, 1, 'h123, 'hA5); step();
        cpu(1, 0, 'h123, 0);    step();
        cpu(0, 0, 0, 0);
        #1;
        check("t1_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        check("t1_rdata",  32'(bus.cpu_rdata),  32'hA5);
        step();

        // Plain fill, no CPU traffic
        dones0 = n_done_seen;
        fill('h010, 4, 'h3C); step(); bus.fill_start = 1'b0;
        drain("t2_drain", 20); step();
        check("t2_done_pulses", n_done_seen - dones0, 32'd1);
        for (int a = 'h00F; a <= 'h014; a++) begin
            cpu(1, 0, a, 0); step();
        end
        cpu(0, 0, 0, 0); step();

        // Fill under continuous CPU reads (CPU wins the start cycle)
        slots0 = n_fill_slots;
        cpu(1, 0, 'h011, 0);
        fill('h400, 10, 'h77);
        for (int n = 0; n < 60 && (n == 0 || m_q.size() > 0 || m_done); n++) begin
            step();
            bus.fill_start = 1'b0;
            if (m_gnt) cpu(1, 0, $urandom_range(0, 15) + 'h400, 0);
        end
        check("t3_fill_slots", n_fill_slots - slots0, 32'd10);
        cpu(0, 0, 0, 0); step();

        // Wrapping fill, then zero-length fill
        fill('h7FE, 4, 'hC1); step(); bus.fill_start = 1'b0;
        drain("t4_drain", 20); step();
        check("t4_mem_wrap", 32'(bram_mem[1]), 32'hC1);
        fill('h100, 0, 'hEE); step(); bus.fill_start = 1'b0;
        step(); step();

        // Reset in the middle of a fill, then a fresh fill
        fill('h200, 8, 'h5A); step(); bus.fill_start = 1'b0;
        step(); step();
        do_reset();
        step(); step();
        fill('h220, 3, 'h6B); step(); bus.fill_start = 1'b0;
        drain("t5_drain", 20); step();

        // Start while busy is ignored
        fill('h300, 6, 'h11); step();
        fill('h380, 5, 'h99); step(); bus.fill_start = 1'b0;
        drain("t6_drain", 20); step();
        check("t6_ignored", 32'(bram_mem['h380]), 32'd0);

        // Random traffic
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                if ($urandom_range(0, 99) < 65)
                    cpu(1, $urandom_range(0, 1), $urandom_range(0, 63) + (($urandom_range(0, 7) == 0) ? 'h7E0 : 0),
                        $urandom_range(0, 255));
                else
                    cpu(0, 0, 0, 0);
            end
            if ($urandom_range(0, 99) < 8)
                fill($urandom_range(0, DEPTH - 1) & (($urandom_range(0, 1) != 0) ? 'h03F : 'h7FF),
                     ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12), $urandom_range(0, 255));
            else
                bus.fill_start = 1'b0;
            step();
            hold = bus.cpu_req && !m_gnt;
        end
        cpu(0, 0, 0, 0);
        bus.fill_start = 1'b0;
        drain("rand_drain", 40);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
